sd_clk_gen: RTL and testbench
=============================

SD_CLK_GEN -- requirements
Module: sd_clk_gen

Interface
REQ-001 Parameter DIV_WIDTH, default 16: width of the half-period divider register.
REQ-002 Parameter CNT_WIDTH, default 16: width of the burst-count register.
REQ-003 Parameter DIV_RESET, default 0: divider value loaded at reset.
REQ-004 Port clk  input  1: single clock domain, rising edge.
REQ-005 Port reset_n  input  1: reset, asynchronous assert, active-low.
REQ-006 Port address  input  3: Avalon-MM word address.
REQ-007 Port chipselect  input  1: slave select.
REQ-008 Port write_n  input  1: active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-009 Port writedata  input  32: write data.
REQ-010 Port readdata  output  32: combinational read data for the current address; unused bits 0.
REQ-011 Port out_port  output  1: registered SD clock output.
REQ-012 Port irq  output  1: level interrupt, equal to done AND irq_en.

Function
REQ-013 Register map, shall be as follows:
- 0 DATA: bit0 = manual level (R/W); reads return current out_port.
- 1 CONTROL: bit0 mode (0 manual, 1 auto), bit1 idle level, bit2 irq_en.
- 2 DIVIDER: half-period = DIVIDER+1 clk cycles.
- 3 COUNT: write N starts a burst; reads return remaining periods.
- 4 STATUS: bit0 busy (RO), bit1 done (sticky, write 1 to clear).
- 5-7: read 0, writes ignored.
REQ-014 Manual mode: out_port shall equal the DATA bit0 register, updating one cycle after the write.
REQ-015 Auto mode FSM states: IDLE, PH_A, PH_B.
- IDLE: out_port = idle level.
- PH_A: out_port = NOT idle level.
- PH_B: out_port = idle level.
REQ-016 In IDLE, a COUNT write with N>0 in auto mode shall load remaining=N, clear the half-period counter and enter PH_A; out_port changes on the clock edge after the write cycle.
REQ-017 PH_A shall last exactly DIVIDER+1 cycles, then go to PH_B.
REQ-018 PH_B shall last DIVIDER+1 cycles, then decrement remaining.
- remaining reaches 0: go to IDLE and set done.
- otherwise: go to PH_A.
REQ-019 busy shall be 1 in PH_A and PH_B, and 0 in IDLE.
REQ-020 A COUNT write with N=0 while busy shall abort: IDLE on the next cycle, remaining=0, done not set.
REQ-021 A COUNT write with N>0 while busy shall reload remaining=N without disturbing the current phase or its counter.
REQ-022 A COUNT write in manual mode shall be ignored.
REQ-023 A DIVIDER write while busy shall take effect at the next phase boundary; the current phase completes with the old value.
REQ-024 Clearing CONTROL.mode while busy shall abort as REQ-020, and out_port shall take the manual level on the next cycle.
REQ-025 Changing the idle level while busy shall take effect at the next phase boundary.
REQ-026 If the done set event and a STATUS write-1-to-clear occur in the same cycle, set shall win.
REQ-027 The half-period counter shall be DIV_WIDTH bits wide; DIVIDER=0 gives out_port toggling every cycle (period 2 clk).
REQ-028 Register writes shall use only the low DIV_WIDTH/CNT_WIDTH bits; readback shall be zero-extended.

Reset
REQ-029 On reset_n=0 the block shall immediately reset to:
- out_port=0, DATA=0, mode=0, idle level=0, irq_en=0
- DIVIDER=DIV_RESET, remaining=0, done=0, irq=0, FSM=IDLE
REQ-030 Reset asserted mid-burst shall abort the burst with no done and no irq after release.
REQ-031 The first write after reset release shall be accepted.

Verification
REQ-032 Legacy manual: write DATA=1, then DATA=0 -> out_port is 1 then 0, each one cycle after its write; DATA read returns out_port.
REQ-033 Burst: CONTROL=0x5, DIVIDER=2, COUNT=4 -> exactly 4 high pulses of 3 cycles each, separated by 3-cycle lows; 24 cycles busy; done=1; irq=1.
REQ-034 Fastest clock: DIVIDER=0, COUNT=3 -> out_port sequence 1,0,1,0,1,0 then idle 0; STATUS reads 0x2.
REQ-035 Abort: COUNT=10 with DIVIDER=1, then COUNT=0 after 5 cycles -> out_port returns to idle level next cycle; done=0; COUNT reads 0.
REQ-036 Simultaneous: STATUS write 0x2 in the same cycle the burst finishes -> done reads 1 and irq stays asserted.
REQ-037 Reset mid-burst: assert reset_n=0 during PH_A -> out_port=0 asynchronously; all registers at reset values after release.

Source files
------------

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: Avalon-MM programmable SD clock generator. Drives out_port either
// from a software-written level (manual) or as a counted burst of clock periods (auto).
module sd_clk_gen #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_DIVIDER = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_e;

    // Software-visible configuration.
    logic                 data_q,     data_d;
    logic                 mode_q,     mode_d;
    logic                 idle_lvl_q, idle_lvl_d;
    logic                 irq_en_q,   irq_en_d;
    logic [DIV_WIDTH-1:0] divider_q,  divider_d;

    // Burst engine.
    state_e               state_q,     state_d;
    logic [DIV_WIDTH-1:0] hp_cnt_q,    hp_cnt_d;
    logic [DIV_WIDTH-1:0] ph_div_q,    ph_div_d;
    logic                 ph_idle_q,   ph_idle_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 done_q,      done_d;
    logic                 out_q,       out_d;

    logic                 wr_en;
    logic                 wr_data, wr_ctrl, wr_div, wr_cnt, wr_stat;
    logic [CNT_WIDTH-1:0] cnt_wdata;
    logic                 cnt_zero;
    logic                 busy;
    logic                 phase_end;
    logic                 reload;
    logic                 abort;
    logic                 done_set;
    logic                 unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign wr_data   = wr_en && (address == REG_DATA);
    assign wr_ctrl   = wr_en && (address == REG_CONTROL);
    assign wr_div    = wr_en && (address == REG_DIVIDER);
    assign wr_cnt    = wr_en && (address == REG_COUNT);
    assign wr_stat   = wr_en && (address == REG_STATUS);

    assign cnt_wdata = writedata[CNT_WIDTH-1:0];
    assign cnt_zero  = (cnt_wdata == '0);
    assign busy      = (state_q != IDLE);
    assign phase_end = (hp_cnt_q == ph_div_q);

    // A nonzero COUNT write while running replaces the period count in place.
    assign reload    = busy && wr_cnt && !cnt_zero;
    // Stopping a burst: COUNT=0, or leaving auto mode.
    assign abort     = busy && ((wr_cnt && cnt_zero) || (wr_ctrl && !writedata[0]));

    assign unused_wdata = ^writedata;

    // NOTE: every always_comb output gets its hold value first, so no path
    // through the block can leave a signal unassigned and infer a latch.
    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        idle_lvl_d = idle_lvl_q;
        irq_en_d   = irq_en_q;
        divider_d  = divider_q;

        if (wr_data) begin
            data_d = writedata[0];
        end
        if (wr_ctrl) begin
            mode_d     = writedata[0];
            idle_lvl_d = writedata[1];
            irq_en_d   = writedata[2];
        end
        if (wr_div) begin
            divider_d = writedata[DIV_WIDTH-1:0];
        end
    end

    // Divider and idle level are sampled at each phase start, so mid-phase
    // register writes only show up from the following phase onward.
    always_comb begin
        state_d     = state_q;
        hp_cnt_d    = hp_cnt_q;
        ph_div_d    = ph_div_q;
        ph_idle_d   = ph_idle_q;
        remaining_d = remaining_q;
        done_set    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_cnt && mode_q && !cnt_zero) begin
                    state_d     = PH_A;
                    hp_cnt_d    = '0;
                    ph_div_d    = divider_q;
                    ph_idle_d   = idle_lvl_q;
                    remaining_d = cnt_wdata;
                end
            end
            PH_A: begin
                if (phase_end) begin
                    state_d   = PH_B;
                    hp_cnt_d  = '0;
                    ph_div_d  = divider_q;
                    ph_idle_d = idle_lvl_q;
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_WIDTH'(1);
                end
            end
            PH_B: begin
                if (phase_end) begin
                    hp_cnt_d  = '0;
                    ph_div_d  = divider_q;
                    ph_idle_d = idle_lvl_q;
                    if (!reload && remaining_q <= CNT_WIDTH'(1)) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        done_set    = 1'b1;
                    end else begin
                        state_d     = PH_A;
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reload) begin
            remaining_d = cnt_wdata;
        end

        if (abort) begin
            state_d     = IDLE;
            hp_cnt_d    = '0;
            remaining_d = '0;
            done_set    = 1'b0;
        end
    end

    // Set beats a simultaneous write-1-to-clear.
    always_comb begin
        done_d = done_q;
        if (wr_stat && writedata[1]) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    // Output is computed from next-state values so it lands on the same edge
    // as the register or state change that causes it.
    always_comb begin
        out_d = data_d;
        if (mode_d) begin
            unique case (state_d)
                PH_A:    out_d = ~ph_idle_d;
                PH_B:    out_d = ph_idle_d;
                default: out_d = idle_lvl_d;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= 1'b0;
            mode_q      <= 1'b0;
            idle_lvl_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            divider_q   <= DIV_WIDTH'(DIV_RESET);
            state_q     <= IDLE;
            hp_cnt_q    <= '0;
            ph_div_q    <= '0;
            ph_idle_q   <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            mode_q      <= mode_d;
            idle_lvl_q  <= idle_lvl_d;
            irq_en_q    <= irq_en_d;
            divider_q   <= divider_d;
            state_q     <= state_d;
            hp_cnt_q    <= hp_cnt_d;
            ph_div_q    <= ph_div_d;
            ph_idle_q   <= ph_idle_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:    readdata = {31'b0, out_q};
            REG_CONTROL: readdata = {29'b0, irq_en_q, idle_lvl_q, mode_q};
            REG_DIVIDER: readdata = 32'(divider_q);
            REG_COUNT:   readdata = 32'(remaining_q);
            REG_STATUS:  readdata = {30'b0, done_q, busy};
            default:     readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: register access, manual level, auto bursts,
// abort/reload corner cases and asynchronous reset, with a per-cycle scoreboard.
module tb_sd_clk_gen;

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_CONTROL = 3'd1;
    localparam logic [2:0] A_DIVIDER = 3'd2;
    localparam logic [2:0] A_COUNT   = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Expected {busy, out_port} per sampled cycle.
    typedef struct {
        string      tag;
        logic [1:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    sd_clk_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is taken on the following rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic sb_push(input string tag, input logic [1:0] e);
        sb_item_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    // Idle level 0 burst: N periods of (div+1) high then (div+1) low, then idle tail.
    task automatic push_burst(input string tag, input int div, input int n, input int tail);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i <= div; i++) sb_push(tag, 2'b11);
            for (int i = 0; i <= div; i++) sb_push(tag, 2'b10);
        end
        for (int i = 0; i < tail; i++) sb_push(tag, 2'b00);
    endtask

    task automatic sb_pop_check();
        sb_item_t   it;
        logic [1:0] obs;
        address = A_STATUS;
        #1;
        obs = {readdata[0], out_port};
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, 32'(obs), 32'(it.exp));
        end
    endtask

    task automatic run_stream(input int n);
        for (int i = 0; i < n; i++) begin
            sb_pop_check();
            if (i != n - 1) @(negedge clk);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #2;
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values.
        check_reg("rst_data", A_DATA, 32'd0);
        check_reg("rst_control", A_CONTROL, 32'd0);
        check_reg("rst_divider", A_DIVIDER, 32'd0);
        @(negedge clk);
        check_reg("rst_count", A_COUNT, 32'd0);
        check_reg("rst_status", A_STATUS, 32'd0);
        @(negedge clk);

        // Manual mode: out_port follows DATA one cycle after the write.
        check("man_before_wr", 32'(out_port), 32'd0);
        bus_write(A_DATA, 32'd1);
        check("man_out_1", 32'(out_port), 32'd1);
        check_reg("man_rd_1", A_DATA, 32'd1);
        @(negedge clk);
        bus_write(A_DATA, 32'd0);
        check("man_out_0", 32'(out_port), 32'd0);
        check_reg("man_rd_0", A_DATA, 32'd0);
        @(negedge clk);
        bus_write(A_COUNT, 32'd5);
        check_reg("man_count_ignored", A_COUNT, 32'd0);
        check_reg("man_not_busy", A_STATUS, 32'd0);
        @(negedge clk);

        // Unmapped addresses and write truncation.
        bus_write(3'd5, 32'hFFFF_FFFF);
        check_reg("unmapped_5", 3'd5, 32'd0);
        check_reg("unmapped_6", 3'd6, 32'd0);
        check_reg("unmapped_7", 3'd7, 32'd0);
        @(negedge clk);
        check_reg("unmapped_ctrl_kept", A_CONTROL, 32'd0);
        bus_write(A_DIVIDER, 32'hABCD_0005);
        check_reg("div_truncated", A_DIVIDER, 32'h0000_0005);
        @(negedge clk);

        // Burst: DIVIDER=2, COUNT=4 with irq enabled.
        bus_write(A_CONTROL, 32'h5);
        check_reg("ctrl_rd", A_CONTROL, 32'h5);
        @(negedge clk);
        bus_write(A_DIVIDER, 32'd2);
        push_burst("burst4_div2", 2, 4, 2);
        bus_write(A_COUNT, 32'd4);
        run_stream(26);
        check_reg("burst4_status", A_STATUS, 32'h2);
        check("burst4_irq", 32'(irq), 32'd1);
        check_reg("burst4_count", A_COUNT, 32'd0);
        @(negedge clk);

        // Fastest clock: DIVIDER=0, COUNT=3.
        bus_write(A_STATUS, 32'h2);
        check_reg("w1c_status", A_STATUS, 32'h0);
        check("w1c_irq", 32'(irq), 32'd0);
        @(negedge clk);
        bus_write(A_DIVIDER, 32'd0);
        push_burst("burst3_div0", 0, 3, 2);
        bus_write(A_COUNT, 32'd3);
        run_stream(8);
        check_reg("burst3_status", A_STATUS, 32'h2);
        @(negedge clk);

        // Abort: COUNT=10, DIVIDER=1, then COUNT=0 in the middle of a high phase.
        bus_write(A_STATUS, 32'h2);
        bus_write(A_DIVIDER, 32'd1);
        sb_push("abort_pre", 2'b11);
        sb_push("abort_pre", 2'b11);
        sb_push("abort_pre", 2'b10);
        sb_push("abort_pre", 2'b10);
        sb_push("abort_pre", 2'b11);
        bus_write(A_COUNT, 32'd10);
        run_stream(5);
        check_reg("abort_remaining", A_COUNT, 32'd9);
        bus_write(A_COUNT, 32'd0);
        check("abort_out_idle", 32'(out_port), 32'd0);
        check_reg("abort_status", A_STATUS, 32'h0);
        check_reg("abort_count", A_COUNT, 32'd0);
        repeat (10) @(negedge clk);
        check_reg("abort_no_done", A_STATUS, 32'h0);
        check("abort_no_irq", 32'(irq), 32'd0);

        // Divider change mid-phase: current phase ends on the old value.
        bus_write(A_DIVIDER, 32'd1);
        sb_push("divchg", 2'b11);
        sb_push("divchg", 2'b11);
        for (int i = 0; i < 4; i++) sb_push("divchg", 2'b10);
        for (int i = 0; i < 4; i++) sb_push("divchg", 2'b11);
        for (int i = 0; i < 4; i++) sb_push("divchg", 2'b10);
        sb_push("divchg", 2'b00);
        bus_write(A_COUNT, 32'd2);
        sb_pop_check();
        bus_write(A_DIVIDER, 32'd3);
        run_stream(14);
        check_reg("divchg_status", A_STATUS, 32'h2);
        check_reg("divchg_divider", A_DIVIDER, 32'd3);
        @(negedge clk);

        // Done set and write-1-to-clear in the same cycle: set wins.
        bus_write(A_STATUS, 32'h2);
        check("simul_irq_cleared", 32'(irq), 32'd0);
        bus_write(A_DIVIDER, 32'd0);
        sb_push("simul", 2'b11);
        sb_push("simul", 2'b10);
        bus_write(A_COUNT, 32'd1);
        run_stream(2);
        bus_write(A_STATUS, 32'h2);
        check_reg("simul_done", A_STATUS, 32'h2);
        check("simul_irq", 32'(irq), 32'd1);
        @(negedge clk);

        // Leaving auto mode mid-burst with idle level 1.
        bus_write(A_CONTROL, 32'h3);
        check("idle_hi_out", 32'(out_port), 32'd1);
        bus_write(A_DATA, 32'd1);
        bus_write(A_DIVIDER, 32'd3);
        bus_write(A_COUNT, 32'd5);
        check("modeclr_pha_1", 32'(out_port), 32'd0);
        @(negedge clk);
        check("modeclr_pha_2", 32'(out_port), 32'd0);
        bus_write(A_CONTROL, 32'h0);
        check("modeclr_out_manual", 32'(out_port), 32'd1);
        check_reg("modeclr_status", A_STATUS, 32'h2);
        check_reg("modeclr_count", A_COUNT, 32'd0);
        @(negedge clk);

        // Reset during PH_A.
        bus_write(A_CONTROL, 32'h5);
        check("prerst_irq", 32'(irq), 32'd1);
        bus_write(A_DIVIDER, 32'd2);
        bus_write(A_COUNT, 32'd4);
        check("prerst_out", 32'(out_port), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_out", 32'(out_port), 32'd0);
        check("rst_async_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_reg("rst2_data", A_DATA, 32'd0);
        check_reg("rst2_control", A_CONTROL, 32'd0);
        check_reg("rst2_divider", A_DIVIDER, 32'd0);
        @(negedge clk);
        check_reg("rst2_count", A_COUNT, 32'd0);
        check_reg("rst2_status", A_STATUS, 32'd0);
        repeat (30) @(negedge clk);
        check_reg("rst2_status_later", A_STATUS, 32'd0);
        check("rst2_irq_later", 32'(irq), 32'd0);
        check("rst2_out_later", 32'(out_port), 32'd0);
        @(negedge clk);
        bus_write(A_DATA, 32'd1);
        check("rst2_first_write", 32'(out_port), 32'd1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
